// File: rtl/gs_host_emulator.sv
//------------------------------------------------------------------------------
// gs_host_emulator
//
// Emulates the host side of a stimulus/acquisition test. A single test is
// started with iStart: the command word is written once into the command FIFO,
// then N raw samples are pulled from the raw-signal FIFO (standard read
// latency of one cycle). Each sample arrives byte-swapped; it is swapped back
// and accumulated into a 16-bit wrapping checksum. Surplus samples left in the
// FIFO after N reads count as an overrun. Stalls of TIMEOUT idle cycles on
// either FIFO abort the test.
//
// Ports
//   iClk, iReset      clock, synchronous active-high reset
//   iStart, i32Cmd    start request and command ([15:8] = N, 0 means 256)
//   o32CmdData        latched command presented to the command FIFO
//   oCmdWrEn          command FIFO write strobe
//   iCmdFull          command FIFO full
//   oRawRdEn          raw FIFO read strobe
//   iRawEmpty         raw FIFO empty
//   i16RawData        raw FIFO data, valid the cycle after oRawRdEn
//   oBusy             test in progress
//   oDone, oError     one-cycle completion / abort pulses
//   o2ErrCode         01 timeout, 10 overrun, 00 none
//   o16Checksum       running sum of de-swapped samples
//   o9SampleCount     samples received so far
//   dbg_state         current FSM state, for observation only
//
// Handshake: a FIFO transfer happens in exactly the cycle its strobe is high;
// a write strobe is only raised while full is low, a read strobe only while
// empty is low.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module gs_host_emulator #(
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iStart,
    input  logic [31:0] i32Cmd,
    output logic [31:0] o32CmdData,
    output logic        oCmdWrEn,
    input  logic        iCmdFull,
    output logic        oRawRdEn,
    input  logic        iRawEmpty,
    input  logic [15:0] i16RawData,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic [1:0]  o2ErrCode,
    output logic [15:0] o16Checksum,
    output logic [8:0]  o9SampleCount,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_RECV   = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cmd_q, cmd_d;
    logic [15:0] sum_q, sum_d;
    logic [8:0]  count_q, count_d;
    logic [8:0]  issued_q, issued_d;
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  err_q, err_d;
    logic        pend_q, pend_d;   // a read was issued last cycle; data is on i16RawData now

    logic        cmd_wr, raw_rd, done, error;
    logic [8:0]  n_val;
    logic [15:0] tmo_inc;
    logic [15:0] sample;

    assign n_val   = (cmd_q[15:8] == 8'd0) ? 9'd256 : {1'b0, cmd_q[15:8]};
    assign tmo_inc = tmo_q + 16'd1;
    assign sample  = {i16RawData[7:0], i16RawData[15:8]};

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= 32'd0;
            sum_q    <= 16'd0;
            count_q  <= 9'd0;
            issued_q <= 9'd0;
            tmo_q    <= 16'd0;
            err_q    <= 2'b00;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            sum_q    <= sum_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        sum_d    = sum_q;
        count_d  = count_q;
        issued_d = issued_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        pend_d   = 1'b0;
        cmd_wr   = 1'b0;
        raw_rd   = 1'b0;
        done     = 1'b0;
        error    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    cmd_d    = i32Cmd;
                    sum_d    = 16'd0;
                    count_d  = 9'd0;
                    issued_d = 9'd0;
                    tmo_d    = 16'd0;
                    err_d    = 2'b00;
                    state_d  = ST_SEND;
                end
            end

            ST_SEND: begin
                if (!iCmdFull) begin
                    cmd_wr  = 1'b1;
                    tmo_d   = 16'd0;
                    state_d = ST_RECV;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TIMEOUT) begin
                        err_d   = 2'b01;
                        state_d = ST_ERR;
                    end
                end
            end

            ST_RECV: begin
                if (pend_q) begin
                    sum_d   = sum_q + sample;
                    count_d = count_q + 9'd1;
                end
                // The last capture ends the phase; no more reads can be
                // outstanding because issued_q already equals N.
                if (pend_q && (count_q + 9'd1 == n_val)) begin
                    tmo_d   = 16'd0;
                    state_d = ST_FINISH;
                end else if (!iRawEmpty && (issued_q < n_val)) begin
                    raw_rd   = 1'b1;
                    pend_d   = 1'b1;
                    issued_d = issued_q + 9'd1;
                    tmo_d    = 16'd0;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TIMEOUT) begin
                        err_d   = 2'b01;
                        state_d = ST_ERR;
                    end
                end
            end

            ST_FINISH: begin
                // Anything still in the FIFO after N samples is an overrun.
                if (!iRawEmpty) begin
                    err_d   = 2'b10;
                    state_d = ST_ERR;
                end else begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_ERR: begin
                error   = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are suppressed during reset so no FIFO transfer happens in a
    // cycle whose effects the reset edge is about to discard.
    assign oCmdWrEn      = cmd_wr && !iReset;
    assign oRawRdEn      = raw_rd && !iReset;
    assign oDone         = done   && !iReset;
    assign oError        = error  && !iReset;
    assign oBusy         = (state_q != ST_IDLE);
    assign o32CmdData    = cmd_q;
    assign o16Checksum   = sum_q;
    assign o9SampleCount = count_q;
    assign o2ErrCode     = err_q;
    assign dbg_state     = state_q;

endmodule
